// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm path: time field widths, FSM encoding
// and default timing constants.
package alarm_controller_pkg;

  localparam int HR_W   = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CNT_W  = 10;
  localparam int SNZ_W  = 4;

  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int SNOOZE_S_DEF       = 300;
  localparam int MAX_SNOOZE_DEF     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_match.sv
// Time comparator: flags the first cycle of the programmed HH:MM:00 so a
// level-held match raises the trigger only once.
module alarm_match
  import alarm_controller_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [HR_W-1:0]  alm_hr,
  input  logic [MIN_W-1:0] alm_min,
  output logic             trigger
);

  logic match;
  logic match_q;

  assign match = (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == '0);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  assign trigger = match && !match_q && alarm_en;

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring / snooze / auto-off state machine feeding the siren enable.
// Outputs are registered and decoded from the next state.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int SNOOZE_S       = SNOOZE_S_DEF,
  parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [HR_W-1:0]  alm_hr,
  input  logic [MIN_W-1:0] alm_min,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             siren_enb,
  output logic             snoozing,
  output logic [SNZ_W-1:0] snooze_left
);

  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_S - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);
  localparam logic [SNZ_W-1:0] SNZ_ONE   = SNZ_W'(1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] sec_cnt, sec_nxt;
  logic [SNZ_W-1:0] snz_nxt;
  logic             trigger;

  alarm_match u_match (
    .clk_in   (clk_in),
    .rst      (rst),
    .alarm_en (alarm_en),
    .cur_hr   (cur_hr),
    .cur_min  (cur_min),
    .cur_sec  (cur_sec),
    .alm_hr   (alm_hr),
    .alm_min  (alm_min),
    .trigger  (trigger)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sec_cnt     <= '0;
      snooze_left <= SNZ_MAX;
      siren_enb   <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sec_cnt     <= sec_nxt;
      snooze_left <= snz_nxt;
      siren_enb   <= (state_nxt == ST_RINGING);
      snoozing    <= (state_nxt == ST_SNOOZE);
    end
  end

  always_comb begin
    state_nxt = state_q;
    sec_nxt   = sec_cnt;
    snz_nxt   = snooze_left;
    if (!alarm_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_nxt = ST_RINGING;
            snz_nxt   = SNZ_MAX;
          end
        end
        ST_RINGING: begin
          // An exhausted snooze press falls through so the ring timer keeps running.
          if (stop_btn) begin
            state_nxt = ST_IDLE;
          end else if (snooze_btn && (snooze_left != '0)) begin
            state_nxt = ST_SNOOZE;
            snz_nxt   = snooze_left - SNZ_ONE;
          end else if (tick_1hz) begin
            if (sec_cnt == RING_LAST) state_nxt = ST_IDLE;
            else                      sec_nxt   = sec_cnt + CNT_ONE;
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_nxt = ST_IDLE;
          end else if (tick_1hz) begin
            if (sec_cnt == SNZ_LAST) state_nxt = ST_RINGING;
            else                     sec_nxt   = sec_cnt + CNT_ONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    // Every state entry restarts the second counter.
    if (state_nxt != state_q) sec_nxt = '0;
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short timing parameters.
module tb_alarm_controller;
  import alarm_controller_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             tick_1hz;
  logic             alarm_en;
  logic [HR_W-1:0]  cur_hr;
  logic [MIN_W-1:0] cur_min;
  logic [SEC_W-1:0] cur_sec;
  logic [HR_W-1:0]  alm_hr;
  logic [MIN_W-1:0] alm_min;
  logic             snooze_btn;
  logic             stop_btn;
  logic             siren_enb;
  logic             snoozing;
  logic [SNZ_W-1:0] snooze_left;

  int checks = 0;
  int errors = 0;

  alarm_controller #(
    .RING_TIMEOUT_S (5),
    .SNOOZE_S       (3),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .alarm_en    (alarm_en),
    .cur_hr      (cur_hr),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .alm_hr      (alm_hr),
    .alm_min     (alm_min),
    .snooze_btn  (snooze_btn),
    .stop_btn    (stop_btn),
    .siren_enb   (siren_enb),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hr  = HR_W'(h);
    cur_min = MIN_W'(m);
    cur_sec = SEC_W'(s);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    cyc(1);
    snooze_btn = 1'b0;
  endtask

  task automatic press_stop();
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
  endtask

  // Walk the clock across 07:29:59 -> 07:30:00; one edge later the alarm fires.
  task automatic ring_up();
    set_time(7, 29, 59);
    cyc(1);
    set_time(7, 30, 0);
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    alm_hr = 5'd7; alm_min = 6'd30;
    set_time(7, 29, 59);
    #12;
    check("reset_siren", 32'(siren_enb), 32'd0);
    check("reset_snoozing", 32'(snoozing), 32'd0);
    check("reset_left", 32'(snooze_left), 32'd2);
    #11 rst = 1'b0;
    @(negedge clk_in);

    // Trigger on minute boundary, no re-trigger while match is held
    alarm_en = 1'b1;
    cyc(2);
    check("pre_match_siren", 32'(siren_enb), 32'd0);
    set_time(7, 30, 0);
    #1 check("same_cycle_siren", 32'(siren_enb), 32'd0);
    cyc(1);
    check("trigger_siren", 32'(siren_enb), 32'd1);
    check("trigger_left", 32'(snooze_left), 32'd2);
    press_stop();
    check("stop_siren", 32'(siren_enb), 32'd0);
    cyc(10);
    check("held_match_no_retrig", 32'(siren_enb), 32'd0);

    // Auto-off on the 5th tick
    ring_up();
    check("ring2_siren", 32'(siren_enb), 32'd1);
    repeat (4) tick();
    check("ring_after_4_ticks", 32'(siren_enb), 32'd1);
    tick();
    check("ring_timeout_siren", 32'(siren_enb), 32'd0);
    check("ring_timeout_snoozing", 32'(snoozing), 32'd0);

    // Snooze twice, third press ignored
    ring_up();
    check("ring3_siren", 32'(siren_enb), 32'd1);
    press_snooze();
    check("snz1_siren", 32'(siren_enb), 32'd0);
    check("snz1_snoozing", 32'(snoozing), 32'd1);
    check("snz1_left", 32'(snooze_left), 32'd1);
    repeat (2) tick();
    check("snz1_after_2_ticks", 32'(snoozing), 32'd1);
    tick();
    check("snz1_expire_siren", 32'(siren_enb), 32'd1);
    check("snz1_expire_snoozing", 32'(snoozing), 32'd0);
    press_snooze();
    check("snz2_left", 32'(snooze_left), 32'd0);
    check("snz2_snoozing", 32'(snoozing), 32'd1);
    repeat (3) tick();
    check("snz2_expire_siren", 32'(siren_enb), 32'd1);
    press_snooze();
    check("snz3_ignored_siren", 32'(siren_enb), 32'd1);
    check("snz3_ignored_snoozing", 32'(snoozing), 32'd0);
    check("snz3_ignored_left", 32'(snooze_left), 32'd0);
    press_stop();
    check("snz_stop_siren", 32'(siren_enb), 32'd0);

    // Stop beats snooze in the same cycle
    ring_up();
    check("ring4_left", 32'(snooze_left), 32'd2);
    press_snooze();
    repeat (3) tick();
    check("ring4_back_ringing", 32'(siren_enb), 32'd1);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    check("stop_snz_siren", 32'(siren_enb), 32'd0);
    check("stop_snz_snoozing", 32'(snoozing), 32'd0);
    check("stop_snz_left", 32'(snooze_left), 32'd1);
    cyc(3);
    check("idle_left_held", 32'(snooze_left), 32'd1);

    // alarm_en dropped during snooze, then a disarmed trigger
    ring_up();
    press_snooze();
    check("en_drop_pre_snoozing", 32'(snoozing), 32'd1);
    alarm_en = 1'b0;
    cyc(1);
    check("en_drop_snoozing", 32'(snoozing), 32'd0);
    check("en_drop_siren", 32'(siren_enb), 32'd0);
    ring_up();
    cyc(1);
    check("disarmed_trigger_siren", 32'(siren_enb), 32'd0);
    alarm_en = 1'b1;
    cyc(2);
    check("rearm_held_match_siren", 32'(siren_enb), 32'd0);

    // Asynchronous reset mid-ring, then a normal event
    ring_up();
    press_snooze();
    repeat (3) tick();
    check("pre_rst_siren", 32'(siren_enb), 32'd1);
    check("pre_rst_left", 32'(snooze_left), 32'd1);
    set_time(7, 31, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_siren", 32'(siren_enb), 32'd0);
    check("async_rst_left", 32'(snooze_left), 32'd2);
    check("async_rst_snoozing", 32'(snoozing), 32'd0);
    #4 rst = 1'b0;
    @(negedge clk_in);
    cyc(1);
    check("post_rst_idle", 32'(siren_enb), 32'd0);
    ring_up();
    check("post_rst_ring", 32'(siren_enb), 32'd1);
    check("post_rst_left", 32'(snooze_left), 32'd2);
    repeat (5) tick();
    check("post_rst_timeout", 32'(siren_enb), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
